// File: rtl/svs_monitor_ctrl.sv
// Supply-voltage-scaling monitor controller: arms a bank of ring-oscillator
// monitors, captures their counts once, then serially reduces them to min/max.
module svs_monitor_ctrl #(
  parameter int NB_MON    = 30,
  parameter int TARGET_W  = 16,
  parameter int COUNT_W   = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [TARGET_W-1:0]        i_target,
  input  logic [NB_MON-1:0]          i_use_ro,
  input  logic [TIMEOUT_W-1:0]       i_timeout,
  input  logic [COUNT_W-1:0]         i_thresh_lo,
  input  logic [COUNT_W-1:0]         i_thresh_hi,
  output logic                       o_mon_enable,
  output logic [TARGET_W-1:0]        o_mon_target,
  output logic [NB_MON-1:0]          o_mon_use_ro,
  input  logic                       i_mon_valid,
  input  logic [NB_MON*COUNT_W-1:0]  i_mon_count,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [1:0]                 o_status,
  output logic [COUNT_W-1:0]         o_min_count,
  output logic [$clog2(NB_MON)-1:0]  o_min_idx,
  output logic [COUNT_W-1:0]         o_max_count,
  output logic [$clog2(NB_MON)-1:0]  o_max_idx,
  output logic                       o_below,
  output logic                       o_above,
  output logic [2:0]                 o_dbg_state
);

  localparam int IDX_W = $clog2(NB_MON);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_MON - 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_NO_RO   = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  // Handshake: the monitor bank owns i_mon_valid; a count set is accepted on
  // any RUN cycle with i_mon_valid=1, there is no back-pressure toward it.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_RUN    = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [TARGET_W-1:0]  target_q;
  logic [NB_MON-1:0]    use_ro_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic [COUNT_W-1:0]   lo_q, hi_q;
  logic [COUNT_W-1:0]   shadow [NB_MON];

  logic [IDX_W-1:0]     ridx_q;
  logic [COUNT_W-1:0]   run_min_q, run_max_q;
  logic [IDX_W-1:0]     run_min_idx_q, run_max_idx_q;
  logic                 found_q;

  logic [1:0]           status_q;
  logic [COUNT_W-1:0]   min_q, max_q;
  logic [IDX_W-1:0]     min_idx_q, max_idx_q;
  logic                 below_q, above_q;

  logic                 take, capture, clr_cnt, no_ro, reduce_end, upd_status;
  logic [1:0]           status_d;
  logic                 tmo_hit;

  logic [COUNT_W-1:0]   cur;
  logic                 sel;
  logic [COUNT_W-1:0]   min_n, max_n;
  logic [IDX_W-1:0]     min_idx_n, max_idx_n;

  assign tmo_hit = (tmo_q != '0) && (tmo_cnt_q == tmo_q - TIMEOUT_W'(1));

  always_comb begin
    state_d    = state_q;
    take       = 1'b0;
    capture    = 1'b0;
    clr_cnt    = 1'b0;
    no_ro      = 1'b0;
    reduce_end = 1'b0;
    upd_status = 1'b0;
    status_d   = ST_OK;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          take    = 1'b1;
          clr_cnt = 1'b1;
          if (i_use_ro == '0) begin
            state_d    = S_DONE;
            no_ro      = 1'b1;
            upd_status = 1'b1;
            status_d   = ST_NO_RO;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        // Wait out any valid left over from a previous request before arming.
        if (i_abort) begin
          state_d    = S_DONE;
          upd_status = 1'b1;
          status_d   = ST_ABORT;
        end else if (!i_mon_valid) begin
          state_d = S_RUN;
          clr_cnt = 1'b1;
        end else if (tmo_hit) begin
          state_d    = S_DONE;
          upd_status = 1'b1;
          status_d   = ST_TIMEOUT;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d    = S_DONE;
          upd_status = 1'b1;
          status_d   = ST_ABORT;
        end else if (i_mon_valid) begin
          state_d = S_REDUCE;
          capture = 1'b1;
        end else if (tmo_hit) begin
          state_d    = S_DONE;
          upd_status = 1'b1;
          status_d   = ST_TIMEOUT;
        end
      end
      S_REDUCE: begin
        if (i_abort) begin
          state_d    = S_DONE;
          upd_status = 1'b1;
          status_d   = ST_ABORT;
        end else if (ridx_q == LAST_IDX) begin
          state_d    = S_DONE;
          reduce_end = 1'b1;
          upd_status = 1'b1;
          status_d   = ST_OK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strict compares keep the lowest index on ties; the first selected entry
  // always seeds the running values so an all-ones count still reports its index.
  always_comb begin
    cur       = shadow[ridx_q];
    sel       = use_ro_q[ridx_q];
    min_n     = run_min_q;
    min_idx_n = run_min_idx_q;
    max_n     = run_max_q;
    max_idx_n = run_max_idx_q;
    if (sel && (!found_q || cur < run_min_q)) begin
      min_n     = cur;
      min_idx_n = ridx_q;
    end
    if (sel && (!found_q || cur > run_max_q)) begin
      max_n     = cur;
      max_idx_n = ridx_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (capture) begin
      for (int i = 0; i < NB_MON; i++) shadow[i] <= i_mon_count[i*COUNT_W +: COUNT_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      target_q      <= '0;
      use_ro_q      <= '0;
      tmo_q         <= '0;
      lo_q          <= '0;
      hi_q          <= '0;
      tmo_cnt_q     <= '0;
      ridx_q        <= '0;
      run_min_q     <= '1;
      run_max_q     <= '0;
      run_min_idx_q <= '0;
      run_max_idx_q <= '0;
      found_q       <= 1'b0;
      status_q      <= ST_OK;
      min_q         <= '1;
      max_q         <= '0;
      min_idx_q     <= '0;
      max_idx_q     <= '0;
      below_q       <= 1'b0;
      above_q       <= 1'b0;
    end else begin
      if (take) begin
        target_q <= i_target;
        use_ro_q <= i_use_ro;
        tmo_q    <= i_timeout;
        lo_q     <= i_thresh_lo;
        hi_q     <= i_thresh_hi;
      end
      if (clr_cnt)                                  tmo_cnt_q <= '0;
      else if (state_q == S_SETUP || state_q == S_RUN) tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
      if (capture) begin
        ridx_q        <= '0;
        run_min_q     <= '1;
        run_max_q     <= '0;
        run_min_idx_q <= '0;
        run_max_idx_q <= '0;
        found_q       <= 1'b0;
      end else if (state_q == S_REDUCE) begin
        ridx_q        <= ridx_q + IDX_W'(1);
        run_min_q     <= min_n;
        run_max_q     <= max_n;
        run_min_idx_q <= min_idx_n;
        run_max_idx_q <= max_idx_n;
        found_q       <= found_q | sel;
      end
      if (upd_status) status_q <= status_d;
      if (no_ro) begin
        min_q     <= '1;
        max_q     <= '0;
        min_idx_q <= '0;
        max_idx_q <= '0;
        below_q   <= 1'b0;
        above_q   <= 1'b0;
      end else if (reduce_end) begin
        min_q     <= min_n;
        max_q     <= max_n;
        min_idx_q <= min_idx_n;
        max_idx_q <= max_idx_n;
        below_q   <= (min_n < lo_q);
        above_q   <= (max_n > hi_q);
      end
    end
  end

  assign o_mon_enable = (state_q == S_RUN);
  assign o_mon_target = target_q;
  assign o_mon_use_ro = use_ro_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_status     = status_q;
  assign o_min_count  = min_q;
  assign o_min_idx    = min_idx_q;
  assign o_max_count  = max_q;
  assign o_max_idx    = max_idx_q;
  assign o_below      = below_q;
  assign o_above      = above_q;
  assign o_dbg_state  = state_q;

endmodule

// File: doc/svs_monitor_ctrl.md
SVS_MONITOR_CTRL -- requirements
Module: svs_monitor_ctrl

Interface
REQ-001 SHALL have parameter NB_MON, default 30, number of ring-oscillator monitors.
REQ-002 SHALL have parameter TARGET_W, default 16, monitor target width.
REQ-003 SHALL have parameter COUNT_W, default 16, per-monitor count width.
REQ-004 SHALL have parameter TIMEOUT_W, default 20, timeout counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset:
- i_clk  in  1  clock
- i_rst  in  1  reset
REQ-006 SHALL have the request-side ports:
- i_start  in  1  request pulse/level; sampled only in IDLE
- i_abort  in  1  abort in-flight measurement
- i_target  in  TARGET_W  measurement target
- i_use_ro  in  NB_MON  oscillator select mask
- i_timeout  in  TIMEOUT_W  max wait cycles per phase; 0 = no timeout
- i_thresh_lo  in  COUNT_W  low alarm threshold
- i_thresh_hi  in  COUNT_W  high alarm threshold
REQ-007 SHALL have the monitor-side ports:
- o_mon_enable  out  1
- o_mon_target  out  TARGET_W
- o_mon_use_ro  out  NB_MON
- i_mon_valid  in  1
- i_mon_count  in  NB_MON x COUNT_W
REQ-008 SHALL have the result ports:
- o_busy  out  1
- o_done  out  1  one-cycle pulse
- o_status  out  2  0=OK, 1=TIMEOUT, 2=NO_RO, 3=ABORT
- o_min_count  out  COUNT_W
- o_min_idx  out  $clog2(NB_MON)
- o_max_count  out  COUNT_W
- o_max_idx  out  $clog2(NB_MON)
- o_below  out  1  min < thresh_lo
- o_above  out  1  max > thresh_hi

Function
REQ-009 SHALL implement the FSM IDLE -> SETUP -> RUN -> REDUCE -> DONE -> IDLE.
REQ-010 IDLE: on i_start=1, SHALL latch i_target, i_use_ro, i_timeout and the thresholds, and assert o_busy from the next cycle.
REQ-011 IDLE: if the latched mask is all zero, SHALL go directly to DONE with status NO_RO; results SHALL then be min=all-ones, max=0, idx=0, below=0, above=0.
REQ-012 SETUP: SHALL hold o_mon_enable=0 and drive the latched target and mask; SHALL exit to RUN in the first cycle that i_mon_valid=0 (stale valid flush).
REQ-013 RUN: SHALL hold o_mon_enable=1; on the first cycle with i_mon_valid=1, SHALL capture all i_mon_count values into shadow registers, deassert o_mon_enable the next cycle and go to REDUCE.
REQ-014 o_mon_target and o_mon_use_ro SHALL stay stable throughout SETUP and RUN.
REQ-015 SHALL count cycles with a per-phase timeout counter, cleared on each entry to SETUP and to RUN. When the counter reaches i_timeout (nonzero), SHALL go to DONE with status TIMEOUT, o_mon_enable=0, and results unchanged from the previous measurement.
REQ-016 REDUCE: SHALL scan one index per cycle, idx 0..NB_MON-1 (exactly NB_MON cycles), considering only shadow entries with the mask bit set.
REQ-017 REDUCE tie-break: min and max SHALL keep the lowest index on equal counts.
REQ-018 Comparisons SHALL be unsigned and full COUNT_W; o_below and o_above SHALL be computed at the end of REDUCE from the latched thresholds.
REQ-019 DONE: SHALL assert o_done for exactly one cycle, update result outputs in that same cycle, deassert o_busy in the following cycle, then return to IDLE.
REQ-020 Latency: with capture at cycle N, o_done SHALL be at N+NB_MON+1.
REQ-021 Results and status SHALL hold until the next DONE.
REQ-022 i_abort in SETUP, RUN or REDUCE SHALL go to DONE next cycle with status ABORT, o_mon_enable=0, results unchanged; i_abort SHALL be ignored in IDLE and DONE.
REQ-023 Simultaneous abort and valid in RUN: abort SHALL win.
REQ-024 Simultaneous abort and timeout: abort SHALL win.
REQ-025 i_start while busy SHALL be ignored (no queueing).
REQ-026 i_mon_valid outside RUN SHALL be ignored.

Reset
REQ-027 On i_rst=1 at a clock edge, from any state, SHALL return to IDLE.
REQ-028 Reset values: o_mon_enable=0, o_mon_target=0, o_mon_use_ro=0, o_busy=0, o_done=0, o_status=0, o_min_count=all-ones, o_max_count=0, both idx=0, o_below=0, o_above=0.
REQ-029 Reset mid-RUN SHALL drop o_mon_enable in the cycle after the reset edge; no o_done SHALL be produced.

Verification
REQ-030 NB_MON=30, mask=0x3, counts[0]=100, counts[1]=200, thresholds 150/180, valid at cycle N -> o_done at N+31, min=100 idx0, max=200 idx1, below=1, above=1, status OK.
REQ-031 mask=0, start -> o_done within 2 cycles, status NO_RO, o_mon_enable never high.
REQ-032 i_timeout=10, valid never rises -> o_done after RUN has lasted 10 cycles, status TIMEOUT, enable=0, prior results kept.
REQ-033 i_mon_valid held high at start -> stays in SETUP with enable=0 until valid=0; then RUN; counts captured only on the next valid.
REQ-034 counts all 500 with full mask -> min_idx=0, max_idx=0; i_abort in REDUCE cycle 5 -> next cycle o_done with status ABORT.
REQ-035 i_rst pulse during RUN, then a new start -> normal completion; no o_done from the aborted run.
